fetch_ctrl: RTL and testbench

//  Sequences the instruction-fetch stage: owns the PC register and drives a single-outstanding
//  req/gnt/rvalid handshake to instruction memory. Applies branch redirects (PC_src/PC_control)
//  and hazard stalls (PC_hazard/data_hazard), and presents instruction, PC_next and instr_valid to decode.

---
 rtl/fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and drives a single-outstanding
// req/gnt/rvalid handshake, applying branch redirects and hazard stalls.
module fetch_ctrl #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter logic [INSTR_W-1:0]  NOP      = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PC_src,
    input  logic [ADDR_W-1:0]  PC_control,
    input  logic               PC_hazard,
    input  logic               data_hazard,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  PC_next,
    output logic               instr_valid,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d, pc_next_d;
    logic [INSTR_W-1:0] instr_d;
    logic               valid_d, drop, drop_d, req_held, req_held_d;
    logic [15:0]        stall_d;
    logic               hazard, accept;
    logic [ADDR_W-1:0]  pc_plus4;

    assign hazard    = PC_hazard | data_hazard;
    assign pc_plus4  = pc + ADDR_W'(4);
    // Once a request is on the bus it stays up until granted, even if a hazard appears.
    assign imem_req  = (state == REQ) && (req_held || !hazard);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d    = state;
        pc_d       = pc;
        pc_next_d  = PC_next;
        instr_d    = instruction;
        valid_d    = instr_valid;
        drop_d     = drop;
        req_held_d = 1'b0;
        stall_d    = (hazard && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;

        if (instr_valid && !hazard)
            valid_d = 1'b0;

        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (PC_src) begin
                    pc_d    = PC_control;
                    valid_d = 1'b0;
                    instr_d = NOP;
                    if (accept) begin
                        drop_d  = 1'b1;
                        state_d = RESP;
                    end
                end else if (accept) begin
                    state_d = RESP;
                end else begin
                    req_held_d = imem_req;
                end
            end
            RESP: begin
                if (PC_src) begin
                    pc_d    = PC_control;
                    valid_d = 1'b0;
                    instr_d = NOP;
                    // A response arriving with the redirect is simply the one being discarded.
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d   = imem_rdata;
                        pc_d      = pc_plus4;
                        pc_next_d = pc_plus4;
                        valid_d   = 1'b1;
                        state_d   = hazard ? HOLD : REQ;
                    end
                end
            end
            HOLD: begin
                if (PC_src) begin
                    pc_d    = PC_control;
                    valid_d = 1'b0;
                    instr_d = NOP;
                    state_d = REQ;
                end else if (!hazard) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            PC_next     <= RESET_PC;
            instruction <= NOP;
            instr_valid <= 1'b0;
            drop        <= 1'b0;
            req_held    <= 1'b0;
            stall_cnt   <= 16'd0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            PC_next     <= pc_next_d;
            instruction <= instr_d;
            instr_valid <= valid_d;
            drop        <= drop_d;
            req_held    <= req_held_d;
            stall_cnt   <= stall_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: sequencing, stalls, redirects,
// grant back-pressure, mid-transaction reset and PC wrap-around.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_src, PC_hazard, data_hazard;
    logic [31:0] PC_control;
    logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instruction, PC_next;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .PC_src(PC_src), .PC_control(PC_control),
        .PC_hazard(PC_hazard), .data_hazard(data_hazard),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instruction(instruction), .PC_next(PC_next),
        .instr_valid(instr_valid), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs changed afterwards settle before the next check.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered in REQ: grant now, return data one cycle later, verify the load.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] nxt;
        nxt = addr + 32'd4;
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        #1;
        check({tag, "_req_resp"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_valid_resp"}, {31'd0, instr_valid}, 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_DEAD;
        #1;
        check({tag, "_instr"}, instruction, data);
        check({tag, "_pcnext"}, PC_next, nxt);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; PC_src = 1'b0; PC_control = 32'd0; PC_hazard = 1'b0;
        data_hazard = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // 1: reset, then four back-to-back fetches
        repeat (5) cyc();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pcnext", PC_next, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        cyc();
        fetch("f0", 32'h0, 32'hA000_0000);
        fetch("f1", 32'h4, 32'hA000_0001);
        fetch("f2", 32'h8, 32'hA000_0002);
        fetch("f3", 32'hC, 32'hA000_0003);

        // 2: data hazard for three cycles freezes the presented instruction
        data_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hz_req", {31'd0, imem_req}, 32'd0);
            check("hz_instr", instruction, 32'hA000_0003);
            check("hz_pcnext", PC_next, 32'h10);
            check("hz_valid", {31'd0, instr_valid}, 32'd1);
            cyc();
        end
        data_hazard = 1'b0;
        #1;
        check("hz_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        fetch("f4", 32'h10, 32'hA000_0004);

        // 3: redirect while a response is outstanding
        check("rd_addr", imem_addr, 32'h14);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; PC_src = 1'b1; PC_control = 32'h100;
        cyc();
        PC_src = 1'b0;
        #1;
        check("rd_valid", {31'd0, instr_valid}, 32'd0);
        check("rd_instr_nop", instruction, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_rvalid = 1'b0;
        #1;
        check("rd_drop_instr", instruction, 32'd0);
        check("rd_drop_valid", {31'd0, instr_valid}, 32'd0);
        fetch("f5", 32'h100, 32'hA000_0005);

        // 4: grant withheld for five cycles
        for (int i = 0; i < 5; i++) begin
            check("bp_req", {31'd0, imem_req}, 32'd1);
            check("bp_addr", imem_addr, 32'h104);
            cyc();
        end
        fetch("f6", 32'h104, 32'hA000_0006);

        // 5: reset in the middle of a response, late rvalid after release
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_instr", instruction, 32'd0);
        check("mr_pcnext", PC_next, 32'd0);
        check("mr_addr", imem_addr, 32'd0);
        check("mr_stall", {16'd0, stall_cnt}, 32'd0);
        cyc();
        cyc();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
        #1;
        check("mr_idle_req", {31'd0, imem_req}, 32'd0);
        cyc();
        check("mr_late_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_late_instr", instruction, 32'd0);
        imem_rvalid = 1'b0;
        fetch("f7", 32'h0, 32'hA000_0007);

        // 6: redirect to the top of the address space, fetch wraps to zero
        PC_src = 1'b1; PC_control = 32'hFFFF_FFFC;
        cyc();
        PC_src = 1'b0;
        #1;
        check("wr_valid", {31'd0, instr_valid}, 32'd0);
        fetch("f8", 32'hFFFF_FFFC, 32'hA000_0008);
        check("wr_next_addr", imem_addr, 32'h0);
        check("wr_next_req", {31'd0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
